rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, number of requesters sharing the decoded resource; SHALL be >= 2, not necessarily a power of two.
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive cycles one grant SHALL be held; SHALL be >= 1.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_enable  input  1  arbitration enable; when low, no new grant SHALL be issued.
REQ-006 i_req  input  DEPTH  per-requester request, level-sensitive.
REQ-007 i_done  input  1  current owner finished; meaningful only while o_grant_valid=1.
REQ-008 o_grant  output  DEPTH  one-hot grant vector, all-zero when idle.
REQ-009 o_grant_idx  output  $clog2(DEPTH)  binary index of the owner, suitable as a decoder select.
REQ-010 o_grant_valid  output  1  high exactly when o_grant is non-zero.
REQ-011 o_timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-012 States SHALL be IDLE and GRANT; no other states.
REQ-013 IDLE: at an edge where i_enable=1 and i_req!=0, the first set i_req bit at or after the pointer, searching circularly and wrapping from DEPTH-1 to 0, SHALL be granted; the state SHALL then be GRANT.
REQ-014 All outputs SHALL be registered; o_grant, o_grant_idx and o_grant_valid SHALL change at the edge that samples the request, giving 1-cycle request-to-grant latency.
REQ-015 o_grant SHALL always equal a one-hot encoding of o_grant_idx when valid, and 0 otherwise; o_grant_idx SHALL hold its last value when not valid.
REQ-016 GRANT: the hold counter SHALL count grant cycles, starting at 1 in the first grant cycle.
REQ-017 A release SHALL occur at the first edge where any of the following is true in GRANT:
  - (a) i_done=1;
  - (b) i_req[o_grant_idx]=0;
  - (c) the counter equals MAX_HOLD.
REQ-018 On release, o_grant and o_grant_valid SHALL clear, the state SHALL be IDLE, and the pointer SHALL be set to (o_grant_idx+1) mod DEPTH.
REQ-019 After every release there SHALL be at least one idle cycle before the next grant.
REQ-020 o_timeout SHALL be 1 for the single cycle after a release caused solely by (c).
REQ-021 If (c) coincides with (a) or (b), the release SHALL be treated as normal and o_timeout SHALL stay 0.
REQ-022 Requests from non-owners during GRANT SHALL be ignored; changes to i_req bits other than the owner's SHALL NOT affect the grant.
REQ-023 i_enable=0 during GRANT SHALL NOT abort the grant; the grant SHALL run to its normal release.
REQ-024 i_done sampled in IDLE SHALL be ignored.
REQ-025 The counter width SHALL be $clog2(MAX_HOLD+1); the counter SHALL never wrap.

Reset
REQ-026 While i_rst=1, asynchronously and without waiting for a clock edge, the block SHALL force:
  - o_grant=0, o_grant_idx=0, o_grant_valid=0, o_timeout=0;
  - pointer=0, counter=0, state=IDLE.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately; the first arbitration after deassertion SHALL search from index 0.

Verification (DEPTH=4, MAX_HOLD=4)
REQ-028 i_req=0101, i_enable=1, pulse i_done on the 2nd grant cycle -> o_grant=0001 (idx 0) for 2 cycles, 1 idle cycle, then o_grant=0100 (idx 2).
REQ-029 i_req=1111 held, i_done pulsed in every grant's first cycle -> grant order idx 0,1,2,3,0, with an idle cycle between each.
REQ-030 i_req=1000 held, no i_done -> o_grant=1000 for exactly 4 cycles; o_timeout=1 in the following cycle; regrant to idx 3 (the pointer wraps to 0 and finds only bit 3).
REQ-031 Owner idx 1 drops i_req[1] in its 3rd grant cycle -> release at that edge, o_timeout=0; i_done and counter=4 in the same cycle -> o_timeout=0.
REQ-032 Assert i_rst mid-grant of idx 2 -> all outputs 0 before the next edge; after release with i_req=0010 -> grant idx 1.
REQ-033 i_enable=0 with i_req=1111 -> no grant for 10 cycles; raise i_enable -> grant idx at the pointer after the 1-cycle latency.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot/binary grant, per-grant hold limit
// and forced-release timeout pulse. Search is circular from the last owner + 1.
module rr_arbiter #(
    parameter int DEPTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [DEPTH-1:0]         i_req,
    input  logic                     i_done,
    output logic [DEPTH-1:0]         o_grant,
    output logic [$clog2(DEPTH)-1:0] o_grant_idx,
    output logic                     o_grant_valid,
    output logic                     o_timeout
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             owner_req;
    logic             hit_max;
    logic             release_now;

    // Circular priority search starting at ptr; works for non-power-of-two DEPTH.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cand = IDX_W'((int'(ptr) + i) % DEPTH);
            if (!found && i_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign owner_req   = i_req[o_grant_idx];
    assign hit_max     = (cnt == HOLD_MAX);
    assign release_now = i_done | ~owner_req | hit_max;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            o_grant       <= '0;
            o_grant_idx   <= '0;
            o_grant_valid <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable && found) begin
                        state         <= GRANT;
                        o_grant       <= DEPTH'(1) << pick;
                        o_grant_idx   <= pick;
                        o_grant_valid <= 1'b1;
                        cnt           <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state         <= IDLE;
                        o_grant       <= '0;
                        o_grant_valid <= 1'b0;
                        cnt           <= '0;
                        ptr           <= (o_grant_idx == LAST_IDX) ? '0 : o_grant_idx + 1'b1;
                        // Timeout flags only a release forced purely by the hold limit.
                        o_timeout     <= hit_max & ~i_done & owner_req;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with DEPTH=4, MAX_HOLD=4; expected grants are hand-derived.
module tb_rr_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [DEPTH-1:0] req;
    logic             done;
    logic [DEPTH-1:0] grant;
    logic [1:0]       grant_idx;
    logic             grant_valid;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_req        (req),
        .i_done       (done),
        .o_grant      (grant),
        .o_grant_idx  (grant_idx),
        .o_grant_valid(grant_valid),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant state: valid flag, one-hot vector and (when valid) the index.
    task automatic exp_grant(input string tag, input bit v, input int idx);
        check({tag, "_valid"}, 32'(grant_valid), 32'(v));
        if (v) begin
            check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
            check({tag, "_onehot"}, 32'(grant), 32'(1) << idx);
        end else begin
            check({tag, "_zero"}, 32'(grant), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        req    = '0;
        done   = 1'b0;
        #3;
        exp_grant("rst", 1'b0, 0);
        check("rst_idx", 32'(grant_idx), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        step();
        rst = 1'b0;

        // 0101 with done in the 2nd grant cycle
        req = 4'b0101; enable = 1'b1;
        step(); exp_grant("a_g1", 1'b1, 0);
        step(); exp_grant("a_g2", 1'b1, 0);
        done = 1'b1;
        step(); exp_grant("a_idle", 1'b0, 0);
        check("a_idx_hold", 32'(grant_idx), 32'd0);
        check("a_to", 32'(timeout), 32'd0);
        done = 1'b0;
        step(); exp_grant("a_g3", 1'b1, 2);
        req = 4'b0000;
        step(); exp_grant("a_rel", 1'b0, 0);

        // 1111 with done in every first grant cycle: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(); exp_grant($sformatf("b_g%0d", k), 1'b1, k % 4);
            done = 1'b1;
            step(); exp_grant($sformatf("b_i%0d", k), 1'b0, 0);
            done = 1'b0;
        end
        req = 4'b0000;

        // 1000 held: hold limit, timeout pulse, wrap regrant
        do_reset();
        req = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            step(); exp_grant($sformatf("c_h%0d", c), 1'b1, 3);
            check($sformatf("c_to%0d", c), 32'(timeout), 32'd0);
        end
        step(); exp_grant("c_idle", 1'b0, 0);
        check("c_to_pulse", 32'(timeout), 32'd1);
        step(); exp_grant("c_regrant", 1'b1, 3);
        check("c_to_clear", 32'(timeout), 32'd0);
        req = 4'b0000;
        step(); exp_grant("c_rel", 1'b0, 0);
        check("c_to_rel", 32'(timeout), 32'd0);

        // Owner 1 drops request in 3rd cycle; then done coinciding with limit
        do_reset();
        req = 4'b0010;
        step(); exp_grant("d_g1", 1'b1, 1);
        step(); exp_grant("d_g2", 1'b1, 1);
        step(); exp_grant("d_g3", 1'b1, 1);
        req = 4'b0000;
        step(); exp_grant("d_drop", 1'b0, 0);
        check("d_to_drop", 32'(timeout), 32'd0);
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            step(); exp_grant($sformatf("d_h%0d", c), 1'b1, 1);
        end
        done = 1'b1;
        step(); exp_grant("d_done_max", 1'b0, 0);
        check("d_to_done_max", 32'(timeout), 32'd0);
        done = 1'b0; req = 4'b0000;

        // Reset mid-grant of idx 2, then search restarts from 0
        do_reset();
        req = 4'b0100;
        step(); exp_grant("e_g", 1'b1, 2);
        rst = 1'b1;
        #1;
        exp_grant("e_async", 1'b0, 0);
        check("e_async_idx", 32'(grant_idx), 32'd0);
        check("e_async_to", 32'(timeout), 32'd0);
        #1;
        rst = 1'b0;
        req = 4'b0010;
        step(); exp_grant("e_after", 1'b1, 1);
        req = 4'b0000;
        step(); exp_grant("e_rel", 1'b0, 0);

        // Enable low blocks new grants; pointer is now 2
        enable = 1'b0; req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            step(); exp_grant($sformatf("f_off%0d", c), 1'b0, 0);
        end
        enable = 1'b1;
        step(); exp_grant("f_on", 1'b1, 2);
        // Disabling and changing other requests must not disturb the owner
        enable = 1'b0; req = 4'b0100;
        step(); exp_grant("f_keep", 1'b1, 2);
        done = 1'b1;
        step(); exp_grant("f_rel", 1'b0, 0);
        // done in IDLE is ignored; pointer 3 wraps to find idx 2
        enable = 1'b1;
        step(); exp_grant("f_done_idle", 1'b1, 2);
        done = 1'b0; req = 4'b0000;
        step(); exp_grant("f_end", 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
